// File: rtl/alarm_display_if.sv
// Bundle between the alarm sequencer and its sensors, status LEDs, alarm line and 4-digit display.
interface alarm_display_if;
   logic       humo;
   logic [2:0] current;
   logic       Led1;
   logic       Led2;
   logic       Alarma2;
   logic [3:0] sel_display;
   logic [7:0] display;

   modport master (
      output humo, current,
      input  Led1, Led2, Alarma2, sel_display, display
   );

   modport slave (
      input  humo, current,
      output Led1, Led2, Alarma2, sel_display, display
   );
endinterface

// File: rtl/alarm_display_controller.sv
// Smoke/over-current alarm sequencer: input debounce, IDLE/WARN/ALARM/HOLD state machine,
// and a scanned 4-digit 7-segment display showing current, smoke flag and state.
module alarm_display_controller #(
   parameter int unsigned SCAN_DIV   = 50000,
   parameter int unsigned DEB_CYCLES = 1000,
   parameter int unsigned CUR_LIMIT  = 3,
   parameter int unsigned WARN_TICKS = 400,
   parameter int unsigned HOLD_TICKS = 400
) (
   input  logic           clk,
   input  logic           reset,
   alarm_display_if.slave bus
);

   localparam int unsigned TICK_W = $clog2(SCAN_DIV);
   localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
   localparam int unsigned WARN_W = $clog2(WARN_TICKS + 1);
   localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WARN  = 2'd1,
      ST_ALARM = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   logic [TICK_W-1:0] tick_cnt;
   logic              tick_c;
   logic [DEB_W-1:0]  smoke_cnt;
   logic [DEB_W-1:0]  oc_cnt;
   logic              smoke_f;
   logic              oc_f;
   logic              oc_raw_c;
   logic              fault_c;
   state_t            state;
   state_t            state_nxt;
   logic [WARN_W-1:0] warn_cnt;
   logic [WARN_W-1:0] warn_nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_nxt;
   logic              alarm;
   logic [1:0]        dig_idx;
   logic [1:0]        dig_nxt_c;
   logic [3:0]        sel;
   logic [3:0]        sel_c;
   logic [7:0]        seg;
   logic [7:0]        seg_c;

   // Segment pattern {g,f,e,d,c,b,a}, active-low, for digits 0..7.
   function automatic logic [6:0] seg7(input logic [2:0] v);
      logic [6:0] s;
      case (v)
         3'd0:    s = 7'h40;
         3'd1:    s = 7'h79;
         3'd2:    s = 7'h24;
         3'd3:    s = 7'h30;
         3'd4:    s = 7'h19;
         3'd5:    s = 7'h12;
         3'd6:    s = 7'h02;
         default: s = 7'h78;
      endcase
      return s;
   endfunction

   assign tick_c   = (tick_cnt == TICK_W'(SCAN_DIV - 1));
   assign oc_raw_c = (bus.current > 3'(CUR_LIMIT));
   assign fault_c  = smoke_f | oc_f;

   always_ff @(posedge clk) begin
      if (reset)       tick_cnt <= '0;
      else if (tick_c) tick_cnt <= '0;
      else             tick_cnt <= tick_cnt + TICK_W'(1);
   end

   // Filtered flag follows raw only after DEB_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         smoke_cnt <= '0;
         smoke_f   <= 1'b0;
      end else if (bus.humo != smoke_f) begin
         if (smoke_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            smoke_f   <= ~smoke_f;
            smoke_cnt <= '0;
         end else begin
            smoke_cnt <= smoke_cnt + DEB_W'(1);
         end
      end else begin
         smoke_cnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         oc_cnt <= '0;
         oc_f   <= 1'b0;
      end else if (oc_raw_c != oc_f) begin
         if (oc_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            oc_f   <= ~oc_f;
            oc_cnt <= '0;
         end else begin
            oc_cnt <= oc_cnt + DEB_W'(1);
         end
      end else begin
         oc_cnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         warn_cnt <= '0;
         hold_cnt <= '0;
         alarm    <= 1'b0;
      end else begin
         state    <= state_nxt;
         warn_cnt <= warn_nxt;
         hold_cnt <= hold_nxt;
         alarm    <= (state_nxt == ST_ALARM) || (state_nxt == ST_HOLD);
      end
   end

   // Fault loss in WARN and fault return in HOLD take precedence over tick completion.
   always_comb begin
      state_nxt = state;
      warn_nxt  = warn_cnt;
      hold_nxt  = hold_cnt;
      unique case (state)
         ST_IDLE: begin
            if (fault_c) begin
               state_nxt = ST_WARN;
               warn_nxt  = '0;
            end
         end
         ST_WARN: begin
            if (!fault_c) begin
               state_nxt = ST_IDLE;
            end else if (tick_c) begin
               warn_nxt = warn_cnt + WARN_W'(1);
               if (warn_cnt == WARN_W'(WARN_TICKS - 1)) state_nxt = ST_ALARM;
            end
         end
         ST_ALARM: begin
            if (!fault_c) begin
               state_nxt = ST_HOLD;
               hold_nxt  = '0;
            end
         end
         ST_HOLD: begin
            if (fault_c) begin
               state_nxt = ST_ALARM;
            end else if (tick_c) begin
               hold_nxt = hold_cnt + HOLD_W'(1);
               if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Contents for the digit that becomes active at the next tick.
   always_comb begin
      dig_nxt_c = dig_idx + 2'd1;
      sel_c     = ~(4'b0001 << dig_nxt_c);
      seg_c     = 8'hFF;
      case (dig_nxt_c)
         2'd0:    seg_c = {~oc_f, seg7(bus.current)};
         2'd1:    seg_c = {1'b1, seg7(3'(smoke_f))};
         2'd2:    seg_c = 8'hFF;
         default: seg_c = {1'b1, seg7(3'(state))};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dig_idx <= 2'd3;
         sel     <= 4'b1111;
         seg     <= 8'hFF;
      end else if (tick_c) begin
         dig_idx <= dig_nxt_c;
         sel     <= sel_c;
         seg     <= seg_c;
      end
   end

   assign bus.Led1        = smoke_f;
   assign bus.Led2        = oc_f;
   assign bus.Alarma2     = alarm;
   assign bus.sel_display = sel;
   assign bus.display     = seg;

endmodule

// File: tb/tb_alarm_display_controller.sv
// Directed bench for alarm_display_controller with a small scan/debounce/tick configuration.
module tb_alarm_display_controller;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   alarm_display_if bus();

   alarm_display_controller #(
      .SCAN_DIV(4), .DEB_CYCLES(3), .CUR_LIMIT(3), .WARN_TICKS(2), .HOLD_TICKS(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       humo;
      logic [2:0] cur;
      int         clks;
      logic       led1;
      logic       led2;
      logic       alarm;
      logic [3:0] sel;
      logic [7:0] disp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic h, input logic [2:0] c, input int n, input logic l1,
                      input logic l2, input logic al, input logic [3:0] s, input logic [7:0] d);
      vec_t v;
      v.humo = h; v.cur = c; v.clks = n; v.led1 = l1; v.led2 = l2;
      v.alarm = al; v.sel = s; v.disp = d;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_led1"}, 8'(bus.Led1), 8'h00);
      check({tag, "_led2"}, 8'(bus.Led2), 8'h00);
      check({tag, "_alarm"}, 8'(bus.Alarma2), 8'h00);
      check({tag, "_sel"}, 8'(bus.sel_display), 8'h0F);
      check({tag, "_disp"}, bus.display, 8'hFF);
   endtask

   initial begin
      // Edge numbers in the notes count rising edges after the initial reset release.
      add(0, 0, 4,  0, 0, 0, 4'b1110, 8'hC0);  // e4  digit0
      add(0, 0, 4,  0, 0, 0, 4'b1101, 8'hC0);  // e8  digit1
      add(0, 0, 4,  0, 0, 0, 4'b1011, 8'hFF);  // e12 digit2
      add(0, 0, 4,  0, 0, 0, 4'b0111, 8'hC0);  // e16 digit3 IDLE
      add(1, 0, 2,  0, 0, 0, 4'b0111, 8'hC0);  // smoke glitch
      add(0, 0, 2,  0, 0, 0, 4'b1110, 8'hC0);
      add(1, 0, 2,  0, 0, 0, 4'b1110, 8'hC0);
      add(1, 0, 1,  1, 0, 0, 4'b1110, 8'hC0);  // e23 Led1 after 3rd edge
      add(1, 0, 1,  1, 0, 0, 4'b1101, 8'hF9);  // e24 WARN, digit1 smoke=1
      add(0, 0, 3,  0, 0, 0, 4'b1101, 8'hF9);  // clear in WARN
      add(0, 0, 1,  0, 0, 0, 4'b1011, 8'hFF);
      add(0, 0, 4,  0, 0, 0, 4'b0111, 8'hC0);  // e32 back in IDLE
      add(0, 3, 20, 0, 0, 0, 4'b1110, 8'hB0);  // current at limit
      add(0, 4, 2,  0, 0, 0, 4'b1110, 8'hB0);
      add(0, 4, 1,  0, 1, 0, 4'b1110, 8'hB0);  // e55 Led2
      add(0, 4, 1,  0, 1, 0, 4'b1101, 8'hC0);  // e56 WARN
      add(0, 4, 4,  0, 1, 0, 4'b1011, 8'hFF);
      add(0, 4, 3,  0, 1, 0, 4'b1011, 8'hFF);
      add(0, 4, 1,  0, 1, 1, 4'b0111, 8'hF9);  // e64 ALARM, digit3 shows WARN
      add(0, 4, 4,  0, 1, 1, 4'b1110, 8'h19);  // 4 with dp
      add(0, 4, 12, 0, 1, 1, 4'b0111, 8'hA4);  // e80 digit3 ALARM
      add(0, 0, 3,  0, 0, 1, 4'b0111, 8'hA4);  // faults cleared
      add(0, 0, 1,  0, 0, 1, 4'b1110, 8'hC0);  // e84 HOLD
      add(0, 0, 7,  0, 0, 1, 4'b1101, 8'hC0);
      add(0, 0, 1,  0, 0, 0, 4'b1011, 8'hFF);  // e92 HOLD complete
      add(0, 0, 4,  0, 0, 0, 4'b0111, 8'hC0);  // e96 IDLE

      reset = 1'b1;
      bus.humo = 1'b0;
      bus.current = 3'd0;
      clocks(1);
      check_reset_vals("rst_init");
      clocks(1);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         bus.humo    = vecs[i].humo;
         bus.current = vecs[i].cur;
         clocks(vecs[i].clks);
         check($sformatf("vec%0d_led1", i), 8'(bus.Led1), 8'(vecs[i].led1));
         check($sformatf("vec%0d_led2", i), 8'(bus.Led2), 8'(vecs[i].led2));
         check($sformatf("vec%0d_alarm", i), 8'(bus.Alarma2), 8'(vecs[i].alarm));
         check($sformatf("vec%0d_sel", i), 8'(bus.sel_display), 8'(vecs[i].sel));
         check($sformatf("vec%0d_disp", i), bus.display, vecs[i].disp);
      end

      // Second alarm, then re-fault on the tick that would end HOLD.
      bus.current = 3'd5;
      clocks(3);
      check("refault_led2_set", 8'(bus.Led2), 8'h01);
      clocks(1);
      check("refault_digit0_sel", 8'(bus.sel_display), 8'h0E);
      check("refault_digit0_disp", bus.display, 8'h12);
      clocks(7);
      check("refault_alarm_before", 8'(bus.Alarma2), 8'h00);
      clocks(1);
      check("refault_alarm_on", 8'(bus.Alarma2), 8'h01);
      bus.current = 3'd0;
      clocks(3);
      check("refault_led2_clr", 8'(bus.Led2), 8'h00);
      check("refault_alarm_clr", 8'(bus.Alarma2), 8'h01);
      for (int i = 0; i < 16; i++) begin
         if (i == 5) bus.current = 3'd6;
         clocks(1);
         check($sformatf("refault_hold_alarm_c%0d", i), 8'(bus.Alarma2), 8'h01);
      end
      clocks(1);
      check("refault_digit3_sel", 8'(bus.sel_display), 8'h07);
      check("refault_digit3_alarm", bus.display, 8'hA4);

      // Reset while in ALARM with the over-current still present.
      reset = 1'b1;
      clocks(1);
      check_reset_vals("rst_alarm");
      reset = 1'b0;
      clocks(2);
      check("post_rst_led2_deb", 8'(bus.Led2), 8'h00);
      clocks(1);
      check("post_rst_led2", 8'(bus.Led2), 8'h01);
      check("post_rst_alarm", 8'(bus.Alarma2), 8'h00);
      check("post_rst_sel_idle", 8'(bus.sel_display), 8'h0F);
      clocks(1);
      check("post_rst_tick_sel", 8'(bus.sel_display), 8'h0E);
      check("post_rst_tick_disp", bus.display, 8'h02);
      clocks(7);
      check("post_rst_alarm_early", 8'(bus.Alarma2), 8'h00);
      clocks(1);
      check("post_rst_alarm_on", 8'(bus.Alarma2), 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
